// File: rtl/imem_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// imem_dmem_arbiter
// Shares one single-ported unified memory between the fetch stage (instruction
// reads) and the memory stage (loads/stores). Only one transaction is
// outstanding at a time. The data side wins arbitration, except that a
// starvation counter forces a fetch grant after STARVE_MAX consecutive data
// grants while fetch was waiting. A flush cancels the pending or just-granted
// fetch response. Data transactions are never affected by a flush.
//
// Ports
//   clk, rst_n                     clock (rising edge), async active-low reset
//   if_req/if_addr                 fetch read request, held until if_gnt
//   if_gnt/if_rvalid/if_rdata      fetch accept pulse, response pulse, data
//   flush                          redirect: drop the outstanding fetch response
//   d_req/d_we/d_be/d_addr/d_wdata data request (load or store), held until d_gnt
//   d_gnt/d_rvalid/d_rdata         data accept pulse, response/ack pulse, load data
//   mem_req/mem_we/mem_be/
//   mem_addr/mem_wdata             request towards the memory macro
//   mem_ready                      memory accepts the request this cycle
//   mem_rvalid/mem_rdata           memory response (read data or write ack)
// All outputs read 0 while rst_n is low.
// ---------------------------------------------------------------------------
module imem_dmem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_W-1:0]     if_rdata,
    input  logic                  flush,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [DATA_W/8-1:0]   d_be,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_W/8-1:0]   mem_be,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX_C = CNT_W'(STARVE_MAX);
    localparam logic [BE_W-1:0]  BE_ALL       = {BE_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   starve_q, starve_d;
    logic               drop_q, drop_d;

    logic               fetch_sel_s;
    logic               data_sel_s;
    logic               mem_req_s;
    logic               mem_we_s;
    logic [BE_W-1:0]    mem_be_s;
    logic [ADDR_W-1:0]  mem_addr_s;
    logic [DATA_W-1:0]  mem_wdata_s;
    logic               if_gnt_s;
    logic               d_gnt_s;
    logic               if_rvalid_s;
    logic               d_rvalid_s;

    // Saturating increment of the starvation counter.
    function automatic logic [CNT_W-1:0] starve_inc(input logic [CNT_W-1:0] cnt);
        if (cnt == STARVE_MAX_C) begin
            return cnt;
        end else begin
            return cnt + CNT_W'(1);
        end
    endfunction

    // Requester selection: data wins unless fetch has been starved long enough.
    always_comb begin
        fetch_sel_s = if_req & (~d_req | (starve_q == STARVE_MAX_C));
        data_sel_s  = d_req & ~fetch_sel_s;
    end

    // Next-state, counter, drop flag and output decode.
    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        drop_d      = drop_q;
        mem_req_s   = 1'b0;
        mem_we_s    = 1'b0;
        mem_be_s    = {BE_W{1'b0}};
        mem_addr_s  = {ADDR_W{1'b0}};
        mem_wdata_s = {DATA_W{1'b0}};
        if_gnt_s    = 1'b0;
        d_gnt_s     = 1'b0;
        if_rvalid_s = 1'b0;
        d_rvalid_s  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                mem_req_s = if_req | d_req;
                if (fetch_sel_s) begin
                    mem_be_s   = BE_ALL;
                    mem_addr_s = if_addr;
                    if_gnt_s   = mem_ready;
                end else if (data_sel_s) begin
                    mem_we_s    = d_we;
                    // Reads always fetch the full word.
                    mem_be_s    = d_we ? d_be : BE_ALL;
                    mem_addr_s  = d_addr;
                    mem_wdata_s = d_wdata;
                    d_gnt_s     = mem_ready;
                end else begin
                    mem_addr_s = {ADDR_W{1'b0}};
                end

                if (if_gnt_s) begin
                    state_d  = ST_BUSY_I;
                    starve_d = {CNT_W{1'b0}};
                    // A flush in the grant cycle already targets this fetch.
                    drop_d   = flush;
                end else if (d_gnt_s) begin
                    state_d  = ST_BUSY_D;
                    starve_d = if_req ? starve_inc(starve_q) : {CNT_W{1'b0}};
                    drop_d   = 1'b0;
                end else if (!if_req) begin
                    starve_d = {CNT_W{1'b0}};
                    drop_d   = 1'b0;
                end else begin
                    starve_d = starve_q;
                    drop_d   = 1'b0;
                end
            end

            ST_BUSY_I: begin
                if (mem_rvalid) begin
                    // A flush arriving together with the response also kills it.
                    if_rvalid_s = ~drop_q & ~flush;
                    drop_d      = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    drop_d = drop_q | flush;
                end
            end

            ST_BUSY_D: begin
                if (mem_rvalid) begin
                    d_rvalid_s = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    state_d = ST_BUSY_D;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                starve_d = {CNT_W{1'b0}};
                drop_d   = 1'b0;
            end
        endcase
    end

    // State, starvation counter and drop flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            starve_q <= {CNT_W{1'b0}};
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            drop_q   <= drop_d;
        end
    end

    // Outputs are forced low while reset is held.
    assign mem_req   = rst_n & mem_req_s;
    assign mem_we    = rst_n & mem_we_s;
    assign mem_be    = rst_n ? mem_be_s    : {BE_W{1'b0}};
    assign mem_addr  = rst_n ? mem_addr_s  : {ADDR_W{1'b0}};
    assign mem_wdata = rst_n ? mem_wdata_s : {DATA_W{1'b0}};
    assign if_gnt    = rst_n & if_gnt_s;
    assign d_gnt     = rst_n & d_gnt_s;
    assign if_rvalid = rst_n & if_rvalid_s;
    assign d_rvalid  = rst_n & d_rvalid_s;
    assign if_rdata  = rst_n ? mem_rdata : {DATA_W{1'b0}};
    assign d_rdata   = rst_n ? mem_rdata : {DATA_W{1'b0}};

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Testbench for imem_dmem_arbiter: a behavioural memory with configurable
// response latency, and scoreboard queues filled at grant time and drained
// when the arbiter emits a response.
module tb_imem_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        flush;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata  = 32'h0;

    int total = 0;
    int bad   = 0;
    int mem_lat = 1;
    int lat_cnt = 0;

    bit [31:0] arr [0:255];
    bit [3:0]  msk [0:255];

    typedef struct {
        logic        chk;
        logic [31:0] data;
    } exp_t;

    logic [31:0] exp_if[$];
    exp_t        exp_d[$];

    imem_dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .flush(flush),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Power-on content of a memory word, unique per word address.
    function automatic logic [31:0] pat(input logic [31:0] a);
        return {6'h2A, a[9:0], ~a[9:0], 6'h15};
    endfunction

    // Memory macro model: accepts on mem_req&&mem_ready, answers mem_lat cycles later.
    always @(posedge clk) begin : mem_model
        logic [31:0] cur;
        int          idx;
        mem_rvalid <= 1'b0;
        if (lat_cnt > 0) begin
            lat_cnt <= lat_cnt - 1;
            if (lat_cnt == 1) mem_rvalid <= 1'b1;
        end
        if (mem_req && mem_ready) begin
            idx = int'(mem_addr[9:2]);
            cur = pat({mem_addr[31:2], 2'b00});
            for (int b = 0; b < 4; b++) if (msk[idx][b]) cur[8*b +: 8] = arr[idx][8*b +: 8];
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be[b]) begin
                        arr[idx][8*b +: 8] <= mem_wdata[8*b +: 8];
                        msk[idx][b]        <= 1'b1;
                    end
                end
            end else begin
                mem_rdata <= cur;
            end
            if (mem_lat <= 1) mem_rvalid <= 1'b1;
            else              lat_cnt    <= mem_lat - 1;
        end
    end

    task automatic idle_inputs();
        if_req = 1'b0; if_addr = 32'h0; flush = 1'b0;
        d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;
        mem_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        if_req = 1'b1; if_addr = 32'h44; flush = 1'b0;
        d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h88; d_wdata = 32'h1234_5678;
        mem_ready = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if ({mem_req, mem_we, if_gnt, d_gnt, if_rvalid, d_rvalid} !== 6'b0) begin
            bad++; $display("FAIL rst_ctrl: got %b want 000000", {mem_req, mem_we, if_gnt, d_gnt, if_rvalid, d_rvalid});
        end
        total++;
        if (mem_addr !== 32'h0 || mem_be !== 4'h0 || mem_wdata !== 32'h0) begin
            bad++; $display("FAIL rst_bus: got addr=%h be=%h wdata=%h want 0", mem_addr, mem_be, mem_wdata);
        end
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_idle_req: got %b want 0", mem_req); end
    endtask

    task automatic test_fetch_seq();
        int nxt = 0; int got = 0; int last = -1; int c = 0;
        logic [31:0] e;
        while (got < 3 && c < 40) begin
            @(negedge clk);
            if_req = (nxt < 3); if_addr = 32'(nxt * 4);
            #1;
            if (if_gnt) begin
                exp_if.push_back(pat(if_addr));
                if (last >= 0) begin
                    total++;
                    if (c - last != 2) begin bad++; $display("FAIL fetch_spacing: got %0d cycles want 2", c - last); end
                end
                last = c; nxt++;
            end
            if (if_rvalid) begin
                total++;
                if (exp_if.size() == 0) begin bad++; $display("FAIL fetch_unexpected: got if_rvalid=1 want 0"); end
                else begin
                    e = exp_if.pop_front();
                    if (if_rdata !== e) begin bad++; $display("FAIL fetch_data: got %h want %h", if_rdata, e); end
                end
                got++;
            end
            c++;
        end
        idle_inputs();
        total++;
        if (got != 3) begin bad++; $display("FAIL fetch_count: got %0d want 3", got); end
    endtask

    task automatic test_priority();
        int c = 0; int drv_c = -1; int ig_c = -1; bit d_granted = 0; bit f_done = 0;
        exp_t e; logic [31:0] ef;
        while (!f_done && c < 30) begin
            @(negedge clk);
            if_req = (ig_c < 0); if_addr = 32'h0C;
            d_req = !d_granted; d_we = 1'b0; d_addr = 32'h100;
            #1;
            if (c == 0) begin
                total++;
                if ({d_gnt, if_gnt} !== 2'b10) begin bad++; $display("FAIL prio_first: got d_gnt,if_gnt=%b want 10", {d_gnt, if_gnt}); end
            end
            if (d_gnt) begin exp_d.push_back('{1'b1, pat(32'h100)}); d_granted = 1; end
            if (if_gnt) begin exp_if.push_back(pat(32'h0C)); ig_c = c; end
            if (d_rvalid) begin
                total++;
                if (exp_d.size() == 0) begin bad++; $display("FAIL prio_d_unexpected: got d_rvalid=1 want 0"); end
                else begin
                    e = exp_d.pop_front();
                    if (e.chk && d_rdata !== e.data) begin bad++; $display("FAIL prio_d_data: got %h want %h", d_rdata, e.data); end
                end
                drv_c = c;
            end
            if (if_rvalid) begin
                total++;
                if (exp_if.size() == 0) begin bad++; $display("FAIL prio_if_unexpected: got if_rvalid=1 want 0"); end
                else begin
                    ef = exp_if.pop_front();
                    if (if_rdata !== ef) begin bad++; $display("FAIL prio_if_data: got %h want %h", if_rdata, ef); end
                end
                f_done = 1;
            end
            c++;
        end
        idle_inputs();
        total++;
        if (!(f_done && drv_c >= 0 && ig_c > drv_c)) begin
            bad++; $display("FAIL prio_order: got if_gnt@%0d d_rvalid@%0d done=%0d want if_gnt after d_rvalid", ig_c, drv_c, f_done);
        end
    endtask

    task automatic test_starve();
        int c = 0; int dgn = 0; int ign = 0;
        logic [31:0] daddr = 32'h200;
        exp_t e; logic [31:0] ef;
        while (c < 80 && (ign < 2 || exp_if.size() > 0 || exp_d.size() > 0)) begin
            @(negedge clk);
            if_req = (ign < 2); if_addr = 32'h10 + 32'(ign * 4);
            d_req = (ign < 2); d_we = 1'b0; d_addr = daddr;
            #1;
            if (d_gnt) begin exp_d.push_back('{1'b1, pat(d_addr)}); dgn++; daddr = daddr + 32'h4; end
            if (if_gnt) begin
                total++;
                if (dgn != 4) begin bad++; $display("FAIL starve_run%0d: got %0d d_gnt want 4", ign, dgn); end
                exp_if.push_back(pat(if_addr)); dgn = 0; ign++;
            end
            if (d_rvalid) begin
                total++;
                if (exp_d.size() == 0) begin bad++; $display("FAIL starve_d_unexpected: got d_rvalid=1 want 0"); end
                else begin
                    e = exp_d.pop_front();
                    if (d_rdata !== e.data) begin bad++; $display("FAIL starve_d_data: got %h want %h", d_rdata, e.data); end
                end
            end
            if (if_rvalid) begin
                total++;
                if (exp_if.size() == 0) begin bad++; $display("FAIL starve_if_unexpected: got if_rvalid=1 want 0"); end
                else begin
                    ef = exp_if.pop_front();
                    if (if_rdata !== ef) begin bad++; $display("FAIL starve_if_data: got %h want %h", if_rdata, ef); end
                end
            end
            c++;
        end
        idle_inputs();
        total++;
        if (ign != 2 || exp_if.size() != 0 || exp_d.size() != 0) begin
            bad++; $display("FAIL starve_timeout: got %0d if_gnt want 2", ign);
        end
    endtask

    task automatic test_flush(input int lat, input int fl_off);
        int c = 0; bit g40 = 0; bit done = 0;
        logic [31:0] ef;
        mem_lat = lat;
        while (!done && c < 30) begin
            @(negedge clk);
            flush   = (c == fl_off);
            if_req  = (c == 0) || !g40;
            if_addr = (c == 0) ? 32'h20 : 32'h40;
            #1;
            if (c == 0) begin
                total++;
                if (if_gnt !== 1'b1) begin bad++; $display("FAIL flush_gnt20_l%0d_o%0d: got %b want 1", lat, fl_off, if_gnt); end
            end else if (if_gnt) begin
                exp_if.push_back(pat(32'h40)); g40 = 1;
            end
            if (if_rvalid) begin
                total++;
                if (exp_if.size() == 0) begin bad++; $display("FAIL flush_dropped_l%0d_o%0d: got if_rvalid=1 for 0x20 want 0", lat, fl_off); end
                else begin
                    ef = exp_if.pop_front();
                    if (if_rdata !== ef) begin bad++; $display("FAIL flush_data40: got %h want %h", if_rdata, ef); end
                    done = 1;
                end
            end
            c++;
        end
        idle_inputs();
        mem_lat = 1;
        total++;
        if (!done) begin bad++; $display("FAIL flush_timeout_l%0d_o%0d: got no 0x40 response want one", lat, fl_off); end
    endtask

    task automatic test_store_load();
        int c = 0; int k = 0; int got = 0;
        logic [31:0] tmp; exp_t e;
        tmp = pat(32'h80);
        while (got < 2 && c < 30) begin
            @(negedge clk);
            d_req = (k < 2); d_addr = 32'h80; d_be = 4'b0011; d_wdata = 32'hDEADBEEF;
            d_we = (k == 0);
            flush = (k == 1);
            #1;
            if (d_gnt && k == 0) begin
                total++;
                if (mem_be !== 4'b0011 || mem_we !== 1'b1 || mem_wdata !== 32'hDEADBEEF || mem_addr !== 32'h80) begin
                    bad++; $display("FAIL store_bus: got be=%b we=%b wd=%h a=%h want 0011 1 deadbeef 80", mem_be, mem_we, mem_wdata, mem_addr);
                end
                exp_d.push_back('{1'b0, 32'h0}); k++;
            end else if (d_gnt && k == 1) begin
                total++;
                if (mem_be !== 4'hF || mem_we !== 1'b0) begin
                    bad++; $display("FAIL load_bus: got be=%b we=%b want 1111 0", mem_be, mem_we);
                end
                exp_d.push_back('{1'b1, {tmp[31:16], 16'hBEEF}}); k++;
            end
            if (d_rvalid) begin
                total++;
                if (exp_d.size() == 0) begin bad++; $display("FAIL sl_unexpected: got d_rvalid=1 want 0"); end
                else begin
                    e = exp_d.pop_front();
                    if (e.chk && d_rdata !== e.data) begin bad++; $display("FAIL load_data: got %h want %h", d_rdata, e.data); end
                end
                got++;
            end
            c++;
        end
        idle_inputs();
        total++;
        if (got != 2) begin bad++; $display("FAIL sl_count: got %0d d_rvalid want 2", got); end
    endtask

    task automatic test_ready_stall();
        int c = 0; bit done = 0;
        logic [31:0] ef;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if_req = 1'b1; if_addr = 32'h30; mem_ready = 1'b0;
            #1;
            total++;
            if (mem_req !== 1'b1 || if_gnt !== 1'b0 || mem_addr !== 32'h30) begin
                bad++; $display("FAIL stall_%0d: got req=%b gnt=%b addr=%h want 1 0 30", i, mem_req, if_gnt, mem_addr);
            end
        end
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        total++;
        if (if_gnt !== 1'b1) begin bad++; $display("FAIL stall_release: got %b want 1", if_gnt); end
        else exp_if.push_back(pat(32'h30));
        while (!done && c < 10) begin
            @(negedge clk);
            if_req = 1'b0;
            #1;
            if (if_rvalid) begin
                total++;
                if (exp_if.size() == 0) begin bad++; $display("FAIL stall_unexpected: got if_rvalid=1 want 0"); end
                else begin
                    ef = exp_if.pop_front();
                    if (if_rdata !== ef) begin bad++; $display("FAIL stall_data: got %h want %h", if_rdata, ef); end
                end
                done = 1;
            end
            c++;
        end
        idle_inputs();
        total++;
        if (!done) begin bad++; $display("FAIL stall_timeout: got no response want one"); end
    endtask

    task automatic test_reset_mid();
        bit saw_rv = 0; bit done = 0;
        exp_t e;
        mem_lat = 4;
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h104;
        #1;
        total++;
        if (d_gnt !== 1'b1) begin bad++; $display("FAIL rmid_gnt: got %b want 1", d_gnt); end
        @(negedge clk);
        rst_n = 1'b0; if_req = 1'b1; if_addr = 32'h8;
        #1;
        total++;
        if ({mem_req, if_gnt, d_gnt, if_rvalid, d_rvalid} !== 5'b0 || d_rdata !== 32'h0 || mem_addr !== 32'h0) begin
            bad++; $display("FAIL rmid_outputs: got ctl=%b rd=%h a=%h want 0", {mem_req, if_gnt, d_gnt, if_rvalid, d_rvalid}, d_rdata, mem_addr);
        end
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            if (mem_rvalid) saw_rv = 1;
            total++;
            if (d_rvalid !== 1'b0 || if_rvalid !== 1'b0) begin
                bad++; $display("FAIL rmid_late_rvalid: got d=%b i=%b want 0 0", d_rvalid, if_rvalid);
            end
        end
        total++;
        if (!saw_rv) begin bad++; $display("FAIL rmid_model: got no late mem_rvalid want one"); end
        mem_lat = 1;
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h104;
        #1;
        total++;
        if (d_gnt !== 1'b1) begin bad++; $display("FAIL rmid_idle_gnt: got %b want 1", d_gnt); end
        else exp_d.push_back('{1'b1, pat(32'h104)});
        for (int i = 0; i < 5 && !done; i++) begin
            @(negedge clk);
            d_req = 1'b0;
            #1;
            if (d_rvalid) begin
                total++;
                if (exp_d.size() == 0) begin bad++; $display("FAIL rmid_unexpected: got d_rvalid=1 want 0"); end
                else begin
                    e = exp_d.pop_front();
                    if (d_rdata !== e.data) begin bad++; $display("FAIL rmid_data: got %h want %h", d_rdata, e.data); end
                end
                done = 1;
            end
        end
        idle_inputs();
        total++;
        if (!done) begin bad++; $display("FAIL rmid_timeout: got no response want one"); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_fetch_seq();
        test_priority();
        test_starve();
        test_flush(1, 1);
        test_flush(3, 0);
        test_flush(3, 2);
        test_store_load();
        test_ready_stall();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion want finish");
        $fatal(1);
    end

endmodule
